// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer around a 4:1 mux: steps select 0..3, samples y per channel, presents a 4-bit word.
// Optional MUX_SCAN_CONT_EN: after each handshake a new scan starts immediately, without start.
module mux4_scan_ctrl #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y,
   output logic [1:0] s,
   output logic       busy,
   output logic [3:0] data,
   output logic       valid,
   input  logic       ready,
   output logic [1:0] dbg_state_o
);

   // Handshake: data/valid are held stable while valid=1; the word transfers on the edge where valid and ready are both high.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_C = SETTLE[3:0];

   state_t     state_q, state_d;
   logic [1:0] s_q, s_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] data_q, data_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= 2'd0;
         cnt_q   <= 4'd0;
         data_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SEL;
               s_d     = 2'd0;
               cnt_d   = 4'd0;
               data_d  = 4'd0;
            end
         end
         SEL: begin
            // Each channel is held SETTLE extra cycles; the capture happens on its last cycle.
            if (cnt_q != SETTLE_C) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               data_d[s_q] = y;
               cnt_d       = 4'd0;
               if (s_q == 2'd3) begin
                  state_d = HOLD;
               end else begin
                  s_d = s_q + 2'd1;
               end
            end
         end
         HOLD: begin
            if (ready) begin
`ifdef MUX_SCAN_CONT_EN
               state_d = SEL;
               data_d  = 4'd0;
`else
               state_d = IDLE;
`endif
               s_d   = 2'd0;
               cnt_d = 4'd0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign s           = s_q;
   assign data        = data_q;
   assign busy        = (state_q != IDLE);
   assign valid       = (state_q == HOLD);
   assign dbg_state_o = state_q;

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
- Sequencer that sits directly around the 4:1 mux.
- Upstream: drives the mux select lines, stepping through channels 0..3.
- Downstream: samples the mux output on each channel and assembles the results into a 4-bit word.
- Presents the word to the next stage with a valid/ready handshake. Lets a single 1-bit mux output be read back as a full 4-bit snapshot of the mux inputs.

Parameters:
- SETTLE, 1, extra cycles each select value is held before y is sampled. Range 0..15.

Ports:
- clk    input   1  system clock; all logic on rising edge.
- rst    input   1  synchronous, active-high reset.
- start  input   1  scan request; sampled only in IDLE.
- y      input   1  mux output, combinational from the current s.
- s      output  2  mux select, registered.
- busy   output  1  high from start acceptance until handshake completion.
- data   output  4  captured word; data[k] = y sampled while s==k.
- valid  output  1  data holds a complete scan.
- ready  input   1  downstream accepts data when valid and ready are both high.

Behaviour:
- Reset, single clock, synchronous active-high: on rst=1 at a clk edge, s=0, busy=0, valid=0, data=0, state=IDLE, settle counter=0. Reset takes priority over all other inputs.
- States: IDLE, SEL, HOLD.
- IDLE:
  - start=1 -> SEL, with s=0, cnt=0, data=0, busy=1.
  - start=0 -> stay in IDLE.
- SEL:
  - If cnt != SETTLE: cnt <= cnt+1, s unchanged.
  - If cnt == SETTLE: data[s] <= y, cnt <= 0.
  - After that capture: if s==3 -> HOLD with valid=1; otherwise s <= s+1.
  - Each channel occupies SETTLE+1 cycles.
- Latency: valid rises 4*(SETTLE+1) clock edges after the edge that accepted start. SETTLE=1 gives 8; SETTLE=0 gives 4.
- HOLD:
  - valid=1; data, s (=3) and busy are stable.
  - ready=1 -> valid=0, busy=0, s=0, go to IDLE on that edge.
  - ready=0 -> hold indefinitely.
- start is ignored while busy=1, including in the handshake cycle. If start is still high in IDLE afterwards, a new scan is accepted on the next edge.
- valid never asserts outside HOLD. data is updated only in SEL; its value is meaningful only while valid=1.
- Reset mid-scan or mid-HOLD aborts the scan; reset values apply on the next edge. No partial word is ever presented.
- Counter width is 4 bits and must not wrap for any legal SETTLE.
- s increments 0->1->2->3 only, never wraps within a scan.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- Defined, continuous mode: a HOLD handshake (ready=1) goes directly to SEL with s=0, cnt=0, data=0, busy held at 1, valid=0. start is not needed after the first scan, and it is still only sampled in IDLE.
  - Back-to-back period is 4*(SETTLE+1)+1 cycles when ready is tied high.
  - rst returns the block to IDLE.
- Undefined: the handshake returns to IDLE as described above. No continuous-mode logic is present.

Test Plan:
1. Reset: rst=1 for 2 edges with random start/ready/y -> s=0, busy=0, valid=0, data=4'b0000; remains idle while start=0.
2. SETTLE=1, bench mux model with i=4'b1010, one-cycle start pulse -> s sequence 0,0,1,1,2,2,3,3; valid=1 exactly 8 edges after acceptance; data=4'b1010; busy=1 throughout.
3. Backpressure: i=4'b0111, ready=0 for 5 cycles after valid -> valid, data=4'b0111 and s=3 stable; ready=1 -> next edge valid=0, busy=0, s=0.
4. Reset mid-scan: rst pulse at 3rd SEL cycle -> next edge all outputs at reset values. A later start with i=4'b0110 yields data=4'b0110 with no stale bits.
5. Start handling: start pulses during SEL/HOLD are ignored (no restart, s sequence unaffected). start held high continuously -> new scan accepted on the edge after return to IDLE.
6. SETTLE=0, i=4'b1111 -> valid 4 edges after start. With MUX_SCAN_CONT_EN and ready=1 -> valid pulses every 5 cycles, busy stays 1, each data=4'b1111.
